// File: rtl/pingpong_bram.sv
// Two-bank ping-pong buffer: the writer fills one bank while the reader drains the other,
// with ownership passed by commit/release. Optional macro PINGPONG_FILL_LEVEL_EN adds rd_fill_words.
module pingpong_bram #(
  parameter int DATA_WIDTH   = 64,
  parameter int BANK_DEPTH   = 4096,
  parameter int READ_LATENCY = 1,
  localparam int NBE = DATA_WIDTH / 8,
  localparam int BO  = $clog2(NBE),
  localparam int WA  = $clog2(BANK_DEPTH),
  localparam int AW  = WA + BO
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [NBE-1:0]        wr_be,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_din,
  input  logic                  wr_commit,
  output logic                  wr_ready,
  output logic                  wr_bank,
  output logic                  wr_overflow,
  input  logic                  rd_en,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_dout,
  output logic                  rd_valid,
  output logic                  rd_bank_valid,
  output logic                  rd_bank,
  input  logic                  rd_release,
`ifdef PINGPONG_FILL_LEVEL_EN
  output logic [1:0]            full_count,
  output logic [WA:0]           rd_fill_words
`else
  output logic [1:0]            full_count
`endif
);

  typedef enum logic [1:0] {
    BANK_FREE = 2'd0,
    BANK_FILL = 2'd1,
    BANK_FULL = 2'd2
  } bank_state_e;

  bank_state_e bank_q [2];
  bank_state_e bank_d [2];

  logic       wr_bank_q, wr_bank_d;
  logic       wr_ready_q, wr_ready_d;
  logic       wr_overflow_q, wr_overflow_d;
  logic       rd_bank_q, rd_bank_d;
  logic       rd_bank_valid_q, rd_bank_valid_d;
  logic [1:0] full_count_q, full_count_d;
  logic       rd_vld1_q, rd_vld1_d;

  logic       commit_ok;
  logic       release_ok;
  logic       wr_other;
  logic       rd_cand;
  logic       mem_we;
  logic       rd_fire;
  logic [WA:0] wr_word_addr;
  logic [WA:0] rd_word_addr;

  logic [DATA_WIDTH-1:0] mem [2*BANK_DEPTH];
  logic [DATA_WIDTH-1:0] rd_mem_q;

  assign commit_ok    = wr_commit & wr_ready_q;
  assign release_ok   = rd_release & rd_bank_valid_q;
  assign wr_other     = ~wr_bank_q;
  assign mem_we       = rst & wr_en & wr_ready_q;
  assign rd_fire      = rst & rd_en & rd_bank_valid_q;
  assign wr_word_addr = {wr_bank_q, wr_addr[AW-1:BO]};
  assign rd_word_addr = {rd_bank_q, rd_addr[AW-1:BO]};
  assign rd_vld1_d    = rd_fire;

  // Bank ownership: apply commit/release, then hand free banks to the writer and full ones to the reader
  always_comb begin
    bank_d          = bank_q;
    wr_bank_d       = wr_bank_q;
    wr_ready_d      = wr_ready_q;
    wr_overflow_d   = wr_overflow_q;
    rd_bank_d       = rd_bank_q;
    rd_bank_valid_d = rd_bank_valid_q;
    rd_cand         = rd_bank_q;
    full_count_d    = full_count_q;

    if (!wr_ready_q && (wr_en || wr_commit)) begin
      wr_overflow_d = 1'b1;
    end else begin
      wr_overflow_d = wr_overflow_q;
    end

    for (int b = 0; b < 2; b++) begin
      if (commit_ok && (wr_bank_q == 1'(b))) begin
        bank_d[b] = BANK_FULL;
      end else if (release_ok && (rd_bank_q == 1'(b))) begin
        bank_d[b] = BANK_FREE;
      end else begin
        bank_d[b] = bank_q[b];
      end
    end

    if (commit_ok) begin
      if (bank_d[wr_other] == BANK_FREE) begin
        bank_d[wr_other] = BANK_FILL;
        wr_bank_d        = wr_other;
        wr_ready_d       = 1'b1;
      end else begin
        wr_ready_d = 1'b0;
      end
    end else if (!wr_ready_q && release_ok) begin
      bank_d[rd_bank_q] = BANK_FILL;
      wr_bank_d         = rd_bank_q;
      wr_ready_d        = 1'b1;
    end else begin
      wr_ready_d = wr_ready_q;
    end

    // With only two banks, the oldest FULL bank is either the one just committed or the reader's sibling
    if (release_ok || !rd_bank_valid_q) begin
      rd_cand = release_ok ? ~rd_bank_q : wr_bank_q;
      if (bank_d[rd_cand] == BANK_FULL) begin
        rd_bank_valid_d = 1'b1;
        rd_bank_d       = rd_cand;
      end else begin
        rd_bank_valid_d = 1'b0;
        rd_bank_d       = rd_bank_q;
      end
    end else begin
      rd_bank_valid_d = rd_bank_valid_q;
      rd_bank_d       = rd_bank_q;
    end

    full_count_d = {1'b0, (bank_d[0] == BANK_FULL)} + {1'b0, (bank_d[1] == BANK_FULL)};
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      bank_q[0]       <= BANK_FILL;
      bank_q[1]       <= BANK_FREE;
      wr_bank_q       <= 1'b0;
      wr_ready_q      <= 1'b1;
      wr_overflow_q   <= 1'b0;
      rd_bank_q       <= 1'b0;
      rd_bank_valid_q <= 1'b0;
      full_count_q    <= 2'd0;
      rd_vld1_q       <= 1'b0;
    end else begin
      bank_q          <= bank_d;
      wr_bank_q       <= wr_bank_d;
      wr_ready_q      <= wr_ready_d;
      wr_overflow_q   <= wr_overflow_d;
      rd_bank_q       <= rd_bank_d;
      rd_bank_valid_q <= rd_bank_valid_d;
      full_count_q    <= full_count_d;
      rd_vld1_q       <= rd_vld1_d;
    end
  end

  // Byte-lane write port; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < NBE; i++) begin
        if (wr_be[i]) begin
          mem[wr_word_addr][8*i +: 8] <= wr_din[8*i +: 8];
        end
      end
    end
  end

  // Read port register; it holds between reads and doubles as rd_dout at latency 1
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_mem_q <= {DATA_WIDTH{1'b0}};
    end else if (rd_fire) begin
      rd_mem_q <= mem[rd_word_addr];
    end else begin
      rd_mem_q <= rd_mem_q;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] rd_dout2_q, rd_dout2_d;
    logic                  rd_vld2_q, rd_vld2_d;

    always_comb begin
      rd_vld2_d  = rd_vld1_q;
      rd_dout2_d = rd_vld1_q ? rd_mem_q : rd_dout2_q;
    end

    // Output stage; reset also drops a read still sitting in the first stage
    always_ff @(posedge clk) begin
      if (!rst) begin
        rd_dout2_q <= {DATA_WIDTH{1'b0}};
        rd_vld2_q  <= 1'b0;
      end else begin
        rd_dout2_q <= rd_dout2_d;
        rd_vld2_q  <= rd_vld2_d;
      end
    end

    assign rd_dout  = rd_dout2_q;
    assign rd_valid = rd_vld2_q;
  end else begin : g_lat1
    assign rd_dout  = rd_mem_q;
    assign rd_valid = rd_vld1_q;
  end

  if (BO > 0) begin : g_addr_lsb
    logic unused_lsb;
    assign unused_lsb = ^{wr_addr[BO-1:0], rd_addr[BO-1:0]};
  end

`ifdef PINGPONG_FILL_LEVEL_EN
  logic [WA:0] fill_q [2];
  logic [WA:0] fill_d [2];
  logic [WA:0] wr_word_p1;
  logic [WA:0] rd_fill_words_q, rd_fill_words_d;

  assign wr_word_p1 = {1'b0, wr_addr[AW-1:BO]} + {{WA{1'b0}}, 1'b1};

  // Per-bank high-water mark, cleared whenever the bank is handed to the writer
  always_comb begin
    fill_d = fill_q;
    for (int b = 0; b < 2; b++) begin
      if ((bank_d[b] == BANK_FILL) && (bank_q[b] != BANK_FILL)) begin
        fill_d[b] = {(WA+1){1'b0}};
      end else if (mem_we && (|wr_be) && (wr_bank_q == 1'(b)) && (wr_word_p1 > fill_q[b])) begin
        fill_d[b] = wr_word_p1;
      end else begin
        fill_d[b] = fill_q[b];
      end
    end
    if (rd_bank_valid_d) begin
      rd_fill_words_d = fill_d[rd_bank_d];
    end else begin
      rd_fill_words_d = {(WA+1){1'b0}};
    end
  end

  // Fill-level registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      fill_q[0]       <= {(WA+1){1'b0}};
      fill_q[1]       <= {(WA+1){1'b0}};
      rd_fill_words_q <= {(WA+1){1'b0}};
    end else begin
      fill_q          <= fill_d;
      rd_fill_words_q <= rd_fill_words_d;
    end
  end

  assign rd_fill_words = rd_fill_words_q;
`endif

  assign wr_ready      = wr_ready_q;
  assign wr_bank       = wr_bank_q;
  assign wr_overflow   = wr_overflow_q;
  assign rd_bank_valid = rd_bank_valid_q;
  assign rd_bank       = rd_bank_q;
  assign full_count    = full_count_q;

endmodule
